pc_flow_ctrl: RTL and testbench
===============================

Name: pc_flow_ctrl

Overview:
- Sequential stage directly downstream of the ALU in the single-cycle core.
- Each cycle it consumes the current opcode and the ALU's compare flag and carry-out, and holds the architectural flag and carry registers.
- It owns the program counter, so it resolves sequencing, beq/bgt/blt/unconditional branches and halt.
- It runs the core-level start/done handshake and counts executed cycles.

Parameters:
PW, 10, program counter width (instruction memory depth 2^PW)
CW, 16, cycle counter width

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  pulse; begins or restarts execution from PC 0
instruction  input  4  current opcode (same encoding as ALU opcode field)
compare_flag  input  2  ALU compare result: 10 eq, 01 A>B, 00 A<B, 11 none
alu_carry  input  1  ALU carry/shift-out for the current instruction
branch_target  input  PW  absolute target from branch LUT for current instruction
pc  output  PW  current program counter (registered)
flag_q  output  2  latched compare flag (registered)
carry_q  output  1  latched carry, fed back as ALU carry_in_shift (registered)
branch_taken  output  1  combinational: current instruction redirects PC
done  output  1  high while in HALTED (registered)
cycle_count  output  CW  instructions executed since last Start (registered)

Behaviour:
- The clock is Clk. Reset is synchronous and active-high. One clock domain. Reset has priority over every other input.
- Reset values: pc=0, flag_q=2'b11, carry_q=0, done=0, cycle_count=0, state=IDLE.
- States: IDLE, RUN, HALTED.
- IDLE: holds pc, ignores instruction. On Start: go to RUN, pc=0, flag_q=11, carry_q=0, cycle_count=0.
- RUN: executes one instruction per cycle.
  - Start is ignored in RUN.
  - cycle_count increments by 1 per RUN cycle, including the halt cycle, and saturates at 2^CW-1.
- Opcode effects in RUN (registered at the next edge):
  - 7 (compare): flag_q <= compare_flag; carry_q unchanged.
  - 2, 3, 4, 8 (add, sub, addi, shift): carry_q <= alu_carry.
  - All other opcodes: flag_q and carry_q hold.
  - 12: unconditional; branch_taken=1, pc <= branch_target.
  - 9 beq: taken iff flag_q==10.
  - 10 bgt: taken iff flag_q==01.
  - 11 blt: taken iff flag_q==00.
  - flag_q==11 means no compare is valid, so no conditional branch is taken.
  - Branch evaluation uses the registered flag_q, not the same-cycle compare_flag.
  - Taken: pc <= branch_target. Not taken: pc <= pc+1.
  - Branches do not clear flag_q; it persists until the next compare.
  - 15 halt: pc holds, next state HALTED, done <= 1.
  - Any other opcode: pc <= pc+1, modulo 2^PW (pc 2^PW-1 wraps to 0).
- branch_taken is 0 outside RUN and for all non-branch opcodes.
- HALTED: pc, flags and cycle_count hold; done=1. Start behaves as in IDLE (restart), and done clears on that edge.
- Reset asserted mid-RUN: all state returns to reset values on that edge, regardless of opcode or Start.
- Reset and Start high together: reset wins; the block ends in IDLE.

Test Plan:
- Reset, Start, then four opcode-5 instructions -> pc 0,1,2,3,4 on successive edges; cycle_count=4; done=0; branch_taken=0 throughout.
- Compare with compare_flag=10, then beq with target=0x3A -> flag_q=10 after compare; branch_taken=1 on the beq cycle; pc=0x3A next. Repeat with bgt -> not taken, pc=prior+1.
- Sequence: Start, then blt with no prior compare (flag_q=11) -> not taken. Then compare flag=00, then blt target 0x05 -> pc=0x05.
- Add with alu_carry=1, then opcode 0 with alu_carry=0 -> carry_q=1 after the add and still 1 after opcode 0. Then shift with alu_carry=0 -> carry_q=0.
- Force pc to 2^PW-1 via branch, then non-branch -> pc wraps to 0. Then halt -> done=1, pc frozen. Start in HALTED -> pc=0, done=0, cycle_count=0.
- Reset asserted mid-RUN together with Start and opcode 12 -> pc=0, flag_q=11, carry_q=0, state IDLE; no branch applied.

Source files
------------

// File: rtl/pc_flow_ctrl_if.sv
// Handshake and datapath bundle between the ALU side of the core and pc_flow_ctrl.
// The slave modport is the flow controller's view; the master modport drives it.
interface pc_flow_ctrl_if #(
   parameter int PW = 10,
   parameter int CW = 16
);
   logic          Start;
   logic [3:0]    instruction;
   logic [1:0]    compare_flag;
   logic          alu_carry;
   logic [PW-1:0] branch_target;
   logic [PW-1:0] pc;
   logic [1:0]    flag_q;
   logic          carry_q;
   logic          branch_taken;
   logic          done;
   logic [CW-1:0] cycle_count;

   modport master (
      output Start,
      output instruction,
      output compare_flag,
      output alu_carry,
      output branch_target,
      input  pc,
      input  flag_q,
      input  carry_q,
      input  branch_taken,
      input  done,
      input  cycle_count
   );

   modport slave (
      input  Start,
      input  instruction,
      input  compare_flag,
      input  alu_carry,
      input  branch_target,
      output pc,
      output flag_q,
      output carry_q,
      output branch_taken,
      output done,
      output cycle_count
   );
endinterface

// File: rtl/pc_flow_ctrl.sv
// Program-counter and flow-control stage behind the ALU: holds the architectural
// compare flag and carry, resolves branches/halt, and runs the start/done handshake.
module pc_flow_ctrl #(
   parameter int PW = 10,
   parameter int CW = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   pc_flow_ctrl_if.slave bus
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [1:0] FLAG_LT   = 2'b00;
   localparam logic [1:0] FLAG_GT   = 2'b01;
   localparam logic [1:0] FLAG_EQ   = 2'b10;
   localparam logic [1:0] FLAG_NONE = 2'b11;

   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_ADDI = 4'd4;
   localparam logic [3:0] OP_CMP  = 4'd7;
   localparam logic [3:0] OP_SHF  = 4'd8;
   localparam logic [3:0] OP_BEQ  = 4'd9;
   localparam logic [3:0] OP_BGT  = 4'd10;
   localparam logic [3:0] OP_BLT  = 4'd11;
   localparam logic [3:0] OP_JMP  = 4'd12;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [PW-1:0] PC_ONE  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pc_q, pc_d;
   logic [1:0]    flg_q, flg_d;
   logic          cy_q, cy_d;
   logic          done_q, done_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          taken_s;

   // Branch resolution: only in RUN, and conditional branches look at the latched flag.
   always_comb begin
      taken_s = 1'b0;
      if (state_q == ST_RUN) begin
         case (bus.instruction)
            OP_JMP:  taken_s = 1'b1;
            OP_BEQ:  taken_s = (flg_q == FLAG_EQ);
            OP_BGT:  taken_s = (flg_q == FLAG_GT);
            OP_BLT:  taken_s = (flg_q == FLAG_LT);
            default: taken_s = 1'b0;
         endcase
      end else begin
         taken_s = 1'b0;
      end
   end

   // Next-state logic for the sequencer, PC, flags and cycle counter.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flg_d   = flg_q;
      cy_d    = cy_q;
      done_d  = done_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (bus.Start) begin
               state_d = ST_RUN;
               pc_d    = '0;
               flg_d   = FLAG_NONE;
               cy_d    = 1'b0;
               done_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            // The halt cycle is counted too; the counter sticks at all-ones.
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end

            case (bus.instruction)
               OP_CMP:                         flg_d = bus.compare_flag;
               OP_ADD, OP_SUB, OP_ADDI, OP_SHF: cy_d  = bus.alu_carry;
               default: begin
                  flg_d = flg_q;
                  cy_d  = cy_q;
               end
            endcase

            if (bus.instruction == OP_HALT) begin
               pc_d    = pc_q;
               state_d = ST_HALTED;
               done_d  = 1'b1;
            end else if (taken_s) begin
               pc_d = bus.branch_target;
            end else begin
               pc_d = pc_q + PC_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; Reset overrides Start and every opcode.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         flg_q   <= FLAG_NONE;
         cy_q    <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flg_q   <= flg_d;
         cy_q    <= cy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.pc           = pc_q;
   assign bus.flag_q       = flg_q;
   assign bus.carry_q      = cy_q;
   assign bus.branch_taken = taken_s;
   assign bus.done         = done_q;
   assign bus.cycle_count  = cnt_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed table-driven bench for pc_flow_ctrl, plus a counter-saturation
// sequence on a narrow-counter instance.
module tb_pc_flow_ctrl;
   logic clk;
   logic rst;
   logic rst2;

   pc_flow_ctrl_if #(.PW(10), .CW(16)) bus ();
   pc_flow_ctrl_if #(.PW(10), .CW(4))  bus2 ();

   pc_flow_ctrl #(.PW(10), .CW(16)) dut (.Clk(clk), .Reset(rst), .bus(bus));
   pc_flow_ctrl #(.PW(10), .CW(4))  dut2 (.Clk(clk), .Reset(rst2), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       st;
      logic [3:0] op;
      logic [1:0] cmp;
      logic       cy;
      logic [9:0] tgt;
      logic       chk_bt;
      logic       bt;
      logic [9:0] pc;
      logic [1:0] fl;
      logic       c;
      logic       dn;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_chk = 0;
   int   n_bad = 0;

   function automatic void add(logic r, logic s, logic [3:0] o, logic [1:0] cm, logic y,
                               logic [9:0] t, logic cb, logic b, logic [9:0] p,
                               logic [1:0] f, logic c, logic d, logic [15:0] n);
      vec_t v;
      v.rst = r; v.st = s; v.op = o; v.cmp = cm; v.cy = y; v.tgt = t;
      v.chk_bt = cb; v.bt = b; v.pc = p; v.fl = f; v.c = c; v.dn = d; v.cnt = n;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, idx, act, exp);
      end
   endtask

   initial begin
      rst  = 1'b1;
      rst2 = 1'b1;
      bus.Start = 1'b0; bus.instruction = 4'd0; bus.compare_flag = 2'b11;
      bus.alu_carry = 1'b0; bus.branch_target = 10'd0;
      bus2.Start = 1'b0; bus2.instruction = 4'd0; bus2.compare_flag = 2'b11;
      bus2.alu_carry = 1'b0; bus2.branch_target = 10'd0;

      //   rst  st    op     cmp    cy    tgt       cbt  bt    pc        fl     c     dn    cnt
      add(1'b1, 1'b0, 4'd5,  2'b11, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'b11, 1'b0, 1'b0, 16'd0);
      add(1'b0, 1'b0, 4'd5,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 2'b11, 1'b0, 1'b0, 16'd0);
      add(1'b0, 1'b1, 4'd12, 2'b11, 1'b0, 10'h055, 1'b1, 1'b0, 10'h000, 2'b11, 1'b0, 1'b0, 16'd0);
      add(1'b0, 1'b0, 4'd5,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h001, 2'b11, 1'b0, 1'b0, 16'd1);
      add(1'b0, 1'b0, 4'd5,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h002, 2'b11, 1'b0, 1'b0, 16'd2);
      add(1'b0, 1'b0, 4'd5,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h003, 2'b11, 1'b0, 1'b0, 16'd3);
      add(1'b0, 1'b0, 4'd5,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h004, 2'b11, 1'b0, 1'b0, 16'd4);
      add(1'b0, 1'b0, 4'd7,  2'b10, 1'b0, 10'h000, 1'b1, 1'b0, 10'h005, 2'b10, 1'b0, 1'b0, 16'd5);
      add(1'b0, 1'b0, 4'd9,  2'b11, 1'b0, 10'h03A, 1'b1, 1'b1, 10'h03A, 2'b10, 1'b0, 1'b0, 16'd6);
      add(1'b0, 1'b1, 4'd10, 2'b11, 1'b0, 10'h100, 1'b1, 1'b0, 10'h03B, 2'b10, 1'b0, 1'b0, 16'd7);
      add(1'b0, 1'b0, 4'd7,  2'b01, 1'b1, 10'h000, 1'b1, 1'b0, 10'h03C, 2'b01, 1'b0, 1'b0, 16'd8);
      add(1'b0, 1'b0, 4'd10, 2'b00, 1'b0, 10'h200, 1'b1, 1'b1, 10'h200, 2'b01, 1'b0, 1'b0, 16'd9);
      add(1'b0, 1'b0, 4'd2,  2'b11, 1'b1, 10'h000, 1'b1, 1'b0, 10'h201, 2'b01, 1'b1, 1'b0, 16'd10);
      add(1'b0, 1'b0, 4'd0,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h202, 2'b01, 1'b1, 1'b0, 16'd11);
      add(1'b0, 1'b0, 4'd8,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h203, 2'b01, 1'b0, 1'b0, 16'd12);
      add(1'b0, 1'b0, 4'd3,  2'b11, 1'b1, 10'h000, 1'b1, 1'b0, 10'h204, 2'b01, 1'b1, 1'b0, 16'd13);
      add(1'b0, 1'b0, 4'd4,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h205, 2'b01, 1'b0, 1'b0, 16'd14);
      add(1'b0, 1'b0, 4'd12, 2'b11, 1'b0, 10'h3FF, 1'b1, 1'b1, 10'h3FF, 2'b01, 1'b0, 1'b0, 16'd15);
      add(1'b0, 1'b0, 4'd1,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 2'b01, 1'b0, 1'b0, 16'd16);
      add(1'b0, 1'b0, 4'd6,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h001, 2'b01, 1'b0, 1'b0, 16'd17);
      add(1'b0, 1'b0, 4'd15, 2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h001, 2'b01, 1'b0, 1'b1, 16'd18);
      add(1'b0, 1'b0, 4'd12, 2'b10, 1'b1, 10'h123, 1'b1, 1'b0, 10'h001, 2'b01, 1'b0, 1'b1, 16'd18);
      add(1'b0, 1'b1, 4'd5,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 2'b11, 1'b0, 1'b0, 16'd0);
      add(1'b0, 1'b0, 4'd11, 2'b11, 1'b0, 10'h077, 1'b1, 1'b0, 10'h001, 2'b11, 1'b0, 1'b0, 16'd1);
      add(1'b0, 1'b0, 4'd7,  2'b00, 1'b0, 10'h000, 1'b1, 1'b0, 10'h002, 2'b00, 1'b0, 1'b0, 16'd2);
      add(1'b0, 1'b0, 4'd11, 2'b11, 1'b0, 10'h005, 1'b1, 1'b1, 10'h005, 2'b00, 1'b0, 1'b0, 16'd3);
      add(1'b0, 1'b0, 4'd9,  2'b11, 1'b0, 10'h099, 1'b1, 1'b0, 10'h006, 2'b00, 1'b0, 1'b0, 16'd4);
      add(1'b0, 1'b0, 4'd2,  2'b11, 1'b1, 10'h000, 1'b1, 1'b0, 10'h007, 2'b00, 1'b1, 1'b0, 16'd5);
      add(1'b1, 1'b1, 4'd12, 2'b10, 1'b1, 10'h123, 1'b0, 1'b0, 10'h000, 2'b11, 1'b0, 1'b0, 16'd0);
      add(1'b0, 1'b0, 4'd5,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 2'b11, 1'b0, 1'b0, 16'd0);
      add(1'b1, 1'b1, 4'd5,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 2'b11, 1'b0, 1'b0, 16'd0);
      add(1'b0, 1'b0, 4'd5,  2'b11, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 2'b11, 1'b0, 1'b0, 16'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst                = vecs[i].rst;
         bus.Start          = vecs[i].st;
         bus.instruction    = vecs[i].op;
         bus.compare_flag   = vecs[i].cmp;
         bus.alu_carry      = vecs[i].cy;
         bus.branch_target  = vecs[i].tgt;
         #2;
         if (vecs[i].chk_bt) check("branch_taken", i, 32'(bus.branch_taken), 32'(vecs[i].bt));
         @(posedge clk);
         #1;
         check("pc",          i, 32'(bus.pc),          32'(vecs[i].pc));
         check("flag_q",      i, 32'(bus.flag_q),      32'(vecs[i].fl));
         check("carry_q",     i, 32'(bus.carry_q),     32'(vecs[i].c));
         check("done",        i, 32'(bus.done),        32'(vecs[i].dn));
         check("cycle_count", i, 32'(bus.cycle_count), 32'(vecs[i].cnt));
      end

      // Narrow counter: must stop at 15 rather than wrap.
      rst2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0;
      bus2.Start = 1'b1;
      @(posedge clk); #1;
      bus2.Start = 1'b0;
      bus2.instruction = 4'd5;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k == 14) check("sat_cnt14", k, 32'(bus2.cycle_count), 32'd14);
         if (k == 15) check("sat_cnt15", k, 32'(bus2.cycle_count), 32'd15);
      end
      check("sat_cnt_hold", 20, 32'(bus2.cycle_count), 32'd15);
      check("sat_pc", 20, 32'(bus2.pc), 32'd20);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
